// File: rtl/fifo_rr_arb_if.sv
// Bundle between four show-ahead FIFOs, the round-robin arbiter and its downstream sink.
// No storage and no latency: this is wiring only.
// Backpressure: the sink's out_ready throttles the arbiter's pops.
interface fifo_rr_arb_if #(
  parameter int DataWidth = 8
);
  logic [4*DataWidth-1:0] din;
  logic [3:0]             empty;
  logic [3:0]             port_en;
  logic                   out_ready;
  logic [3:0]             rd_en;
  logic [DataWidth-1:0]   out_data;
  logic                   out_valid;
  logic [1:0]             out_src;
  logic                   busy;

  // Arbiter side.
  modport slave (
    input  din, empty, port_en, out_ready,
    output rd_en, out_data, out_valid, out_src, busy
  );

  // FIFO and sink side.
  modport master (
    output din, empty, port_en, out_ready,
    input  rd_en, out_data, out_valid, out_src, busy
  );
endinterface

// File: rtl/fifo_rr_arb.sv
// Round-robin burst arbiter that pops four show-ahead FIFOs into a single registered output word.
// Latency: an eligible port seen in IDLE is popped the next cycle, and the word is on out_data the cycle after.
// Backpressure: a pop happens only when the output register is free or being drained; out_ready=0 stalls without ending the burst.
module fifo_rr_arb #(
  parameter int DataWidth = 8,
  parameter int MaxBurst  = 4
) (
  input logic          rd_clk,
  input logic          rst,
  fifo_rr_arb_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [3:0] LastCnt = 4'(MaxBurst - 1);

  state_e               state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           last_gnt_q, last_gnt_d;
  logic [3:0]           burst_cnt_q, burst_cnt_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [1:0]           out_src_q, out_src_d;
  logic                 out_valid_q, out_valid_d;

  logic [3:0]           elig;
  logic                 can_load;
  logic                 pop;
  logic [1:0]           pick;
  logic                 any_elig;
  logic [DataWidth-1:0] head;

  assign elig     = ~bus.empty & bus.port_en;
  assign can_load = !out_valid_q || bus.out_ready;
  assign head     = bus.din[int'(gnt_q)*DataWidth +: DataWidth];

  // Rotating search for the next eligible port, starting just after the last grant.
  always_comb begin
    pick     = last_gnt_q;
    any_elig = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!any_elig && elig[last_gnt_q + 2'(i)]) begin
        pick     = last_gnt_q + 2'(i);
        any_elig = 1'b1;
      end
    end
  end

  // Next-state and output-register logic; a pop always coincides with capture into out_data.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_elig) begin
          gnt_d       = pick;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        pop = elig[gnt_q] && can_load && !rst;
        if (pop) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
        // A drained or disabled port ends the burst; a pure stall does not.
        if (!elig[gnt_q] || (pop && burst_cnt_q == LastCnt)) begin
          state_d    = IDLE;
          last_gnt_d = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      out_data_d  = head;
      out_src_d   = gnt_q;
      out_valid_d = 1'b1;
    end else if (bus.out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any held word and re-aims the pointer at port 0.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'd0;
      last_gnt_q  <= 2'd3;
      burst_cnt_q <= 4'd0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rd_en     = pop ? (4'b0001 << gnt_q) : 4'b0000;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Bench for fifo_rr_arb: queue-backed FIFOs, a transaction-level arbiter model and an output scoreboard.
// Inputs change 1 ns after the rising edge; rd_en is checked before the next edge and registered outputs after it.
// Directed scenarios run first, followed by a randomized run of FIFO fill, port_en and out_ready.
module tb_fifo_rr_arb;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rr_arb_if #(.DataWidth(DW)) bus ();

  fifo_rr_arb #(.DataWidth(DW), .MaxBurst(MB)) dut (
    .rd_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fq [4][$];
  logic [DW-1:0] sb [$];
  int            seq [4];
  logic [3:0]    en_v;
  logic          ready_v;

  // Model: granted port (-1 when idle), rotation pointer, words in burst, output register.
  int            m_cur;
  int            m_last;
  int            m_cnt;
  logic          m_vld;
  logic [DW-1:0] m_dat;
  int            m_src;

  int         src_log [$];
  int         rd_cnt [4];
  logic [3:0] first_rd;
  int         cons_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int p, input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = {p[1:0], seq[p][5:0]};
      seq[p]++;
      fq[p].push_back(w);
    end
  endtask

  task automatic step();
    logic [3:0]    elig;
    logic [3:0]    exp_rd;
    logic          can;
    logic          pop;
    logic [DW-1:0] wd;
    for (int i = 0; i < 4; i++) begin
      bus.empty[i] = (fq[i].size() == 0);
      bus.din[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : DW'($urandom);
      elig[i] = (fq[i].size() != 0) && en_v[i];
    end
    bus.port_en   = en_v;
    bus.out_ready = ready_v;
    #1;
    can    = !m_vld || ready_v;
    pop    = !rst && (m_cur >= 0) && elig[m_cur] && can;
    exp_rd = pop ? 4'(1 << m_cur) : 4'b0000;
    chk("rd_en", {28'd0, bus.rd_en}, {28'd0, exp_rd});
    for (int i = 0; i < 4; i++) if (bus.rd_en[i]) rd_cnt[i]++;
    if (first_rd == 4'b0000) first_rd = bus.rd_en;

    if (rst) begin
      sb.delete();
      m_cur = -1; m_last = 3; m_cnt = 0;
      m_vld = 1'b0; m_dat = '0; m_src = 0;
    end else begin
      if (bus.out_valid && ready_v) begin
        cons_cnt++;
        src_log.push_back(int'(bus.out_src));
        if (sb.size() == 0) chk("sb_underrun", 32'(sb.size()), 32'd1);
        else chk("sb_word", {24'd0, bus.out_data}, {24'd0, sb.pop_front()});
      end
      if (pop) begin
        wd = fq[m_cur].pop_front();
        sb.push_back(wd);
        m_dat = wd; m_src = m_cur; m_vld = 1'b1; m_cnt++;
      end else if (ready_v && m_vld) begin
        m_vld = 1'b0;
      end
      if (m_cur < 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_cur < 0 && elig[(m_last + k) % 4]) begin
            m_cur = (m_last + k) % 4;
            m_cnt = 0;
          end
        end
      end else if ((pop && m_cnt == MB) || !elig[m_cur]) begin
        m_last = m_cur;
        m_cur  = -1;
      end
    end

    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_vld});
    chk("out_data", {24'd0, bus.out_data}, {24'd0, m_dat});
    chk("out_src", {30'd0, bus.out_src}, 32'(m_src));
    chk("busy", {31'd0, bus.busy}, {31'd0, (m_cur >= 0)});
  endtask

  task automatic clear_logs();
    src_log.delete();
    for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    first_rd = 4'b0000;
    cons_cnt = 0;
  endtask

  initial begin
    logic [DW-1:0] held;
    int            n;
    int            exp_src;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    m_cur = -1; m_last = 3; m_cnt = 0; m_vld = 1'b0; m_dat = '0; m_src = 0;
    en_v = 4'hF; ready_v = 1'b1; rst = 1'b1;
    clear_logs();
    @(posedge clk);
    #1;

    // Reset state.
    step();
    step();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    // Port 2 alone with three words.
    clear_logs();
    push(2, 3);
    repeat (8) step();
    chk("p2_rd_cnt", 32'(rd_cnt[2]), 32'd3);
    chk("p2_words", 32'(src_log.size()), 32'd3);
    for (int k = 0; k < src_log.size(); k++) chk("p2_src", 32'(src_log[k]), 32'd2);
    // Pointer now sits on port 2, so port 3 beats port 1.
    clear_logs();
    push(1, 1);
    push(3, 1);
    repeat (8) step();
    chk("rot_words", 32'(src_log.size()), 32'd2);
    if (src_log.size() == 2) begin
      chk("rot_first", 32'(src_log[0]), 32'd3);
      chk("rot_second", 32'(src_log[1]), 32'd1);
    end

    // All four ports with ten words each.
    rst = 1'b1; step(); rst = 1'b0;
    clear_logs();
    for (int p = 0; p < 4; p++) push(p, 10);
    repeat (70) step();
    chk("rr_words", 32'(src_log.size()), 32'd40);
    for (int k = 0; k < src_log.size() && k < 40; k++) begin
      exp_src = (k < 32) ? (k / 4) % 4 : (k - 32) / 2;
      chk("rr_src_seq", 32'(src_log[k]), 32'(exp_src));
    end

    // Output stall mid-burst on port 0.
    rst = 1'b1; step(); rst = 1'b0;
    clear_logs();
    push(0, 8);
    n = 0;
    while (!bus.out_valid && n < 10) begin step(); n++; end
    chk("stall_first_vld", {31'd0, bus.out_valid}, 32'd1);
    ready_v = 1'b0;
    held = bus.out_data;
    for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    repeat (5) begin
      step();
      chk("stall_data", {24'd0, bus.out_data}, {24'd0, held});
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
    end
    chk("stall_no_pop", 32'(rd_cnt[0]), 32'd0);
    ready_v = 1'b1;
    repeat (20) step();
    chk("stall_delivered", 32'(cons_cnt), 32'd8);

    // port_en[1] dropped mid-burst; grant moves on to port 2.
    clear_logs();
    push(1, 6);
    push(2, 3);
    n = 0;
    while (rd_cnt[1] < 2 && n < 10) begin step(); n++; end
    en_v[1] = 1'b0;
    repeat (10) step();
    chk("drop_no_rd1", 32'(rd_cnt[1]), 32'd2);
    chk("drop_p2_pops", 32'(rd_cnt[2]), 32'd3);
    en_v = 4'hF;
    repeat (15) step();

    // Reset mid-burst with a word held.
    clear_logs();
    push(3, 6);
    push(2, 6);
    n = 0;
    while (!bus.out_valid && n < 10) begin step(); n++; end
    rst = 1'b1;
    step();
    chk("midrst_vld", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    first_rd = 4'b0000;
    repeat (4) step();
    chk("midrst_first_grant", {28'd0, first_rd}, 32'h4);
    repeat (40) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 99) < 30 && fq[p].size() < 16) push(p, 1);
        en_v[p] = ($urandom_range(0, 9) != 0);
      end
      ready_v = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b0; en_v = 4'hF; ready_v = 1'b1;
    repeat (120) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
